// File: rtl/sync_fifo_flagged_if.sv
// Handshake/data bundle for sync_fifo_flagged: the producer/consumer side
// drives requests through the master modport and the FIFO answers on the slave one.
interface sync_fifo_flagged_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic                  flush;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_en;
    logic                  clear_errors;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  fifo_is_empty;
    logic                  fifo_is_full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   words_used;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, write_en, write_data, read_en, clear_errors,
        input  read_data, fifo_is_empty, fifo_is_full, almost_empty, almost_full,
               words_used, overflow, underflow
    );

    modport slave (
        input  flush, write_en, write_data, read_en, clear_errors,
        output read_data, fifo_is_empty, fifo_is_full, almost_empty, almost_full,
               words_used, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with full-depth occupancy count, threshold flags, sticky
// overflow/underflow errors, synchronous flush and show-ahead/registered read.
module sync_fifo_flagged #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 7,
    parameter int ALMOST_FULL_LEVEL  = 120,
    parameter int ALMOST_EMPTY_LEVEL = 8,
    parameter bit SHOWAHEAD          = 1'b1
) (
    input logic              clk,
    input logic              reset,
    sync_fifo_flagged_if.slave bus
);
    localparam int                DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_LVL  = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic empty, full, rd_ok, wr_ok, mem_we;

    // Status decodes only from the registered count.
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    assign rd_ok  = bus.read_en & ~empty;
    assign wr_ok  = bus.write_en & (~full | rd_ok);
    assign mem_we = wr_ok & ~bus.flush & ~reset;

    // Next-state for pointers, count and sticky error flags; flush wins over traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (bus.clear_errors) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            if (wr_ok && !rd_ok) count_d = count_q + (ADDR_WIDTH+1)'(1);
            if (rd_ok && !wr_ok) count_d = count_q - (ADDR_WIDTH+1)'(1);
            // A new error in the clearing cycle keeps the flag set.
            if (bus.write_en && !wr_ok) ovf_d = 1'b1;
            if (bus.read_en && !rd_ok)  unf_d = 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= bus.write_data;
    end

    generate
        if (SHOWAHEAD) begin : g_showahead
            // Head word is presented combinationally; zero while empty.
            assign bus.read_data = empty ? '0 : mem[rd_ptr_q];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] rdata_q;
            // Registered read: load on an accepted read, otherwise hold (flush included).
            always_ff @(posedge clk) begin
                if (reset)                     rdata_q <= '0;
                else if (rd_ok && !bus.flush)  rdata_q <= mem[rd_ptr_q];
            end
            assign bus.read_data = rdata_q;
        end
    endgenerate

    assign bus.fifo_is_empty = empty;
    assign bus.fifo_is_full  = full;
    assign bus.almost_empty  = (count_q <= AE_LVL);
    assign bus.almost_full   = (count_q >= AF_LVL);
    assign bus.words_used    = count_q;
    assign bus.overflow      = ovf_q;
    assign bus.underflow     = unf_q;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed bench for sync_fifo_flagged: a show-ahead instance (A) and a
// registered-read instance (B) checked against hand-computed values.
module tb_sync_fifo_flagged;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sync_fifo_flagged_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) if_a ();
    sync_fifo_flagged_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) if_b ();

    sync_fifo_flagged #(.SHOWAHEAD(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    sync_fifo_flagged #(.SHOWAHEAD(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        if_a.write_en = 1'b0; if_a.read_en = 1'b0;
        if_a.flush = 1'b0; if_a.clear_errors = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        if_a.write_data = '0; if_b.write_data = '0;
        idle_a();
        if_b.write_en = 1'b0; if_b.read_en = 1'b0;
        if_b.flush = 1'b0; if_b.clear_errors = 1'b0;
        step(); step();
        reset = 1'b0;

        // Reset state
        check("rst_empty", if_a.fifo_is_empty, 1);
        check("rst_full",  if_a.fifo_is_full, 0);
        check("rst_ae",    if_a.almost_empty, 1);
        check("rst_af",    if_a.almost_full, 0);
        check("rst_used",  if_a.words_used, 0);
        check("rst_ovf",   if_a.overflow, 0);
        check("rst_unf",   if_a.underflow, 0);
        check("rst_rdata", if_a.read_data, 0);
        check("rst_rdata_b", if_b.read_data, 0);

        // Three writes, three reads in show-ahead mode
        if_a.write_en = 1'b1;
        if_a.write_data = 32'h11; step();
        check("w1_rdata", if_a.read_data, 32'h11);
        check("w1_used",  if_a.words_used, 1);
        check("w1_empty", if_a.fifo_is_empty, 0);
        if_a.write_data = 32'h22; step();
        check("w2_used",  if_a.words_used, 2);
        if_a.write_data = 32'h33; step();
        check("w3_used",  if_a.words_used, 3);
        check("w3_rdata", if_a.read_data, 32'h11);
        if_a.write_en = 1'b0; if_a.read_en = 1'b1;
        step(); check("r1_rdata", if_a.read_data, 32'h22);
        step(); check("r2_rdata", if_a.read_data, 32'h33);
        step();
        check("r3_empty", if_a.fifo_is_empty, 1);
        check("r3_rdata", if_a.read_data, 0);
        check("r3_unf",   if_a.underflow, 0);
        idle_a();

        // Fill to depth, tracking threshold flags
        exp_q.delete();
        if_a.write_en = 1'b1;
        for (int i = 0; i < 128; i++) begin
            if_a.write_data = 32'h100 + i;
            exp_q.push_back(32'h100 + i);
            step();
            check("fill_af", if_a.almost_full, (i + 1) >= 120);
            check("fill_ae", if_a.almost_empty, (i + 1) <= 8);
        end
        check("fill_full", if_a.fifo_is_full, 1);
        check("fill_used", if_a.words_used, 128);
        check("fill_ovf",  if_a.overflow, 0);
        if_a.write_data = 32'hDEAD; step();
        check("ovf_set",  if_a.overflow, 1);
        check("ovf_used", if_a.words_used, 128);
        check("ovf_head", if_a.read_data, 32'h100);
        if_a.write_en = 1'b0; if_a.clear_errors = 1'b1; step();
        check("ovf_clr", if_a.overflow, 0);
        idle_a();

        // Simultaneous read/write at full across pointer wrap
        for (int k = 0; k < 300; k++) begin
            check("stream_rdata", if_a.read_data, exp_q[0]);
            if_a.write_en = 1'b1; if_a.read_en = 1'b1;
            if_a.write_data = 32'h1000 + k;
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(32'h1000 + k);
            check("stream_full", if_a.fifo_is_full, 1);
        end
        check("stream_ovf", if_a.overflow, 0);
        check("stream_unf", if_a.underflow, 0);
        if_a.write_en = 1'b0; if_a.read_en = 1'b1;
        for (int k = 0; k < 128; k++) begin
            check("drain_rdata", if_a.read_data, exp_q[0]);
            void'(exp_q.pop_front());
            step();
        end
        check("drain_empty", if_a.fifo_is_empty, 1);
        idle_a();

        // Read on empty with simultaneous write
        if_a.write_en = 1'b1; if_a.read_en = 1'b1; if_a.write_data = 32'hAA;
        step();
        check("unf_set",   if_a.underflow, 1);
        check("unf_used",  if_a.words_used, 1);
        check("unf_rdata", if_a.read_data, 32'hAA);
        check("unf_ovf",   if_a.overflow, 0);
        idle_a(); if_a.clear_errors = 1'b1; step();
        check("unf_clr", if_a.underflow, 0);
        idle_a(); if_a.read_en = 1'b1; step();
        check("unf_drain", if_a.fifo_is_empty, 1);
        idle_a();

        // Flush with write_en high
        if_a.write_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if_a.write_data = 32'h200 + i; step();
        end
        check("pre_flush_used", if_a.words_used, 50);
        if_a.flush = 1'b1; if_a.write_data = 32'hBAD; step();
        check("flush_used",  if_a.words_used, 0);
        check("flush_empty", if_a.fifo_is_empty, 1);
        check("flush_ae",    if_a.almost_empty, 1);
        check("flush_rdata", if_a.read_data, 0);
        check("flush_ovf",   if_a.overflow, 0);
        check("flush_unf",   if_a.underflow, 0);
        if_a.flush = 1'b0; if_a.write_data = 32'h77; step();
        check("pf_rdata", if_a.read_data, 32'h77);
        check("pf_used",  if_a.words_used, 1);
        idle_a(); if_a.read_en = 1'b1; step();
        check("pf_empty", if_a.fifo_is_empty, 1);
        idle_a();

        // Registered-read instance
        if_b.write_en = 1'b1;
        if_b.write_data = 32'h5; step();
        if_b.write_data = 32'h6; step();
        check("b_used",  if_b.words_used, 2);
        check("b_noread", if_b.read_data, 0);
        if_b.write_en = 1'b0; if_b.read_en = 1'b1; step();
        check("b_r1", if_b.read_data, 32'h5);
        if_b.read_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("b_hold", if_b.read_data, 32'h5);
        end
        if_b.read_en = 1'b1; step();
        check("b_r2", if_b.read_data, 32'h6);
        check("b_empty", if_b.fifo_is_empty, 1);
        if_b.read_en = 1'b0; if_b.flush = 1'b1; step();
        check("b_flush_hold", if_b.read_data, 32'h6);
        if_b.flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
